// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    typedef logic req_id_t;

    localparam int unsigned DEFAULT_MAX_WAIT = 255;
    localparam int          WAIT_W           = 8;

endpackage

// File: rtl/bus_arbiter.sv
// Round-robin arbiter granting fetch (m0) or load/store (m1) access to one
// shared bus, with a wait-cycle timeout that aborts a stalled access.
//
// state    | meaning
// ST_IDLE  | no access in flight; arbitrate and latch the winning request
// ST_BUSY0 | m0 access on the bus, waiting for bus_ready or timeout
// ST_BUSY1 | m1 access on the bus, waiting for bus_ready or timeout
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEFAULT_MAX_WAIT
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_request,
    input  logic        m0_write_enable,
    input  logic [31:0] m0_address,
    input  logic [31:0] m0_write_data,
    input  logic [3:0]  m0_byte_enable,
    output logic        m0_ready,
    output logic        m0_error,
    output logic [31:0] m0_read_data,

    input  logic        m1_request,
    input  logic        m1_write_enable,
    input  logic [31:0] m1_address,
    input  logic [31:0] m1_write_data,
    input  logic [3:0]  m1_byte_enable,
    output logic        m1_ready,
    output logic        m1_error,
    output logic [31:0] m1_read_data,

    output logic [31:0] bus_address,
    output logic [31:0] bus_write_data,
    output logic [3:0]  bus_byte_enable,
    output logic        bus_read_enable,
    output logic        bus_write_enable,
    input  logic [31:0] bus_read_data,
    input  logic        bus_ready
);

    // Counter holds completed wait cycles, so the abort fires in the BUSY
    // cycle where it would reach MAX_WAIT.
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    state_t              state_q, state_d;
    req_id_t             last_q, last_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                we_q, we_d;
    logic [31:0]         addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          be_q, be_d;

    req_id_t             gnt;
    logic                busy;
    logic                timeout;
    logic                finish;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            wait_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            wait_q  <= wait_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        wait_d  = wait_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        gnt     = 1'b0;

        busy    = (state_q != ST_IDLE);
        timeout = busy && !bus_ready && (wait_q == WAIT_LAST);
        finish  = busy && (bus_ready || timeout);

        case (state_q)
            ST_IDLE: begin
                if (m0_request || m1_request) begin
                    gnt     = (m0_request && m1_request) ? ~last_q : m1_request;
                    we_d    = gnt ? m1_write_enable : m0_write_enable;
                    addr_d  = gnt ? m1_address      : m0_address;
                    wdata_d = gnt ? m1_write_data   : m0_write_data;
                    be_d    = gnt ? m1_byte_enable  : m0_byte_enable;
                    last_d  = gnt;
                    wait_d  = '0;
                    state_d = gnt ? ST_BUSY1 : ST_BUSY0;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (finish) begin
                    state_d = ST_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus_address      = busy ? addr_q  : '0;
        bus_write_data   = busy ? wdata_q : '0;
        bus_byte_enable  = busy ? be_q    : '0;
        bus_read_enable  = busy && !we_q;
        bus_write_enable = busy && we_q;

        m0_ready     = finish && (state_q == ST_BUSY0);
        m1_ready     = finish && (state_q == ST_BUSY1);
        m0_error     = m0_ready && !bus_ready;
        m1_error     = m1_ready && !bus_ready;
        m0_read_data = m0_ready ? bus_read_data : '0;
        m1_read_data = m1_ready ? bus_read_data : '0;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter MAX_WAIT, default 255: maximum cycles a granted access waits for bus_ready before abort.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mN_request  input  1  per requester N in {0 = fetch, 1 = load/store}; access request, held until mN_ready.
REQ-005 mN_write_enable  input  1  1 = write access, 0 = read access.
REQ-006 mN_address  input  32  byte address.
REQ-007 mN_write_data  input  32  write data.
REQ-008 mN_byte_enable  input  4  byte lanes.
REQ-009 mN_ready  output  1  one-cycle completion pulse for requester N.
REQ-010 mN_error  output  1  valid with mN_ready; 1 = access aborted by timeout.
REQ-011 mN_read_data  output  32  read data; valid only while mN_ready=1.
REQ-012 bus_address, bus_write_data  output  32 each  shared bus address and write data.
REQ-013 bus_byte_enable  output  4  shared bus byte lanes.
REQ-014 bus_read_enable, bus_write_enable  output  1 each  shared bus strobes; never both 1.
REQ-015 bus_read_data  input  32  returned read data.
REQ-016 bus_ready  input  1  slave completion, sampled while a strobe is high.

Function
REQ-017 States: IDLE, BUSY0, BUSY1; arbitration occurs only in IDLE.
REQ-018 IDLE, exactly one request high: latch that requester's address/data/byte_enable/write_enable; enter BUSYn next edge.
REQ-019 IDLE, both requests high: grant the requester not granted last (round-robin); after reset requester 0 wins first.
REQ-020 BUSYn: bus outputs driven from registered values only; strobes assert in the cycle after the IDLE request cycle.
REQ-021 bus_read_enable = BUSYn and not write; bus_write_enable = BUSYn and write; both 0 in IDLE.
REQ-022 BUSYn with bus_ready=1: mN_ready=1 combinationally that cycle, mN_error=0, mN_read_data=bus_read_data; next state IDLE.
REQ-023 Minimum access: 1 request cycle + 1 bus cycle; one mandatory IDLE cycle between grants.
REQ-024 Wait counter clears on BUSY entry and increments each BUSY cycle without bus_ready.
REQ-025 Counter reaching MAX_WAIT without bus_ready: mN_ready=1, mN_error=1, strobes drop, next state IDLE.
REQ-026 bus_ready and counter == MAX_WAIT in the same cycle: bus_ready wins, error=0.
REQ-027 bus_ready while IDLE: ignored; no ready pulse.
REQ-028 Non-granted requester's mN_ready and mN_error remain 0.
REQ-029 Changes to request inputs during BUSY do not alter the latched access.
REQ-030 Counter is 8 bits; MAX_WAIT range is 1..255.

Reset
REQ-031 On reset: state IDLE, last-grant = requester 1, counter 0, all bus outputs 0, all mN_ready/mN_error 0.
REQ-032 Reset during BUSY aborts the access with no ready pulse; strobes are 0 the cycle after the reset edge.

Structure
REQ-033 Package bus_arbiter_pkg holds the state enum, requester-id typedef (1 bit), and the default MAX_WAIT constant.
REQ-034 Single module with no sub-modules; registered state, latched request, counter, and last-grant flag only.

Verification
REQ-035 m0 reads 0x00000100, slave ready after 2 cycles returning 0xDEADBEEF -> bus_read_enable high 3 cycles, m0_ready one pulse, m0_read_data=0xDEADBEEF, m0_error=0.
REQ-036 m0 and m1 both request from reset -> m0 granted first, m1 granted after one IDLE cycle; repeated contention alternates grants.
REQ-037 m1 writes 0x00000001 to 0xfffffff0 with byte_enable 0xF, bus_ready immediate -> bus_write_enable one cycle with those values, m1_ready the same cycle.
REQ-038 MAX_WAIT=4, bus_ready never asserted -> m0_ready and m0_error pulse on the 4th BUSY cycle, then state IDLE.
REQ-039 Reset asserted mid-BUSY with bus_ready low -> no mN_ready, strobes 0 next cycle, and the next contention grants m0.
REQ-040 bus_ready pulsed in IDLE with no requests -> no ready pulse and no strobes.
